cdc_bus_sequencer: RTL and testbench
====================================

# cdc_bus_sequencer

Source-side controller that shares one multi-bit clock-domain-crossing bus (an `xpm_cdc_array_single` data path plus an `xpm_cdc_single` request toggle) between `NUM_REQ` configuration writers. It arbitrates round-robin and drives the selected word onto the bus. It holds that word stable for a settle interval before flipping a request toggle, then waits for the destination's acknowledge toggle before granting again. The per-bit synchronizers are therefore never sampled while the word is changing. It sits in the `clk` domain in front of the CDC cells; the acknowledge toggle arrives already synchronized into `clk` by an external `xpm_cdc_single`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters. Legal range 2..16.
- `WIDTH`, 32: data word width.
- `SETTLE_CYCLES`, 2: number of cycles `cdc_data` is held stable before `cdc_req_tgl` flips. Must be at least 1.
- `TIMEOUT`, 255: maximum cycles spent in WAIT_ACK before the block aborts the transfer. Must be at least 1.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request. The requester holds it high until it sees `req_ready`.
- `req_data`  in  NUM_REQ*WIDTH  requester i's word sits at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle grant. The requester's data is captured on the edge that ends this cycle.
- `cdc_data`  out  WIDTH  registered word driving the array synchronizer.
- `cdc_req_tgl`  out  1  registered request toggle driving the single-bit synchronizer.
- `cdc_ack_tgl`  in  1  destination acknowledge toggle, already synchronized to `clk`.
- `busy`  out  1  high whenever the state is not IDLE.
- `grant_idx`  out  $clog2(NUM_REQ)  index of the most recent grant.
- `timeout_err`  out  1  sticky flag, set when a transfer times out.
- `err_clr`  in  1  single-cycle clear for `timeout_err`.

## Operation
States and transitions:
- IDLE → SETTLE when any `req_valid` is high and `cdc_ack_tgl == cdc_req_tgl` (parity match). On that transition:
  - the grant goes to the first requester with `req_valid` high, searching from `grant_idx+1` upward with modulo wrap;
  - `req_ready[g]` is driven combinationally high for that single cycle;
  - on the edge, `cdc_data <= req_data[g]` and `grant_idx <= g`.
- SETTLE: the settle counter runs 0..SETTLE_CYCLES-1. On the edge where the counter reaches SETTLE_CYCLES-1, `cdc_req_tgl` inverts and the state moves to WAIT_ACK.
- WAIT_ACK → IDLE on the first cycle `cdc_ack_tgl == cdc_req_tgl`. The timeout counter clears on entry.
- WAIT_ACK → IDLE after TIMEOUT cycles without a parity match. On that edge `timeout_err <= 1`.

Rules:
- No grant is issued while the parity mismatches. After a timeout, the block stays in IDLE until the late acknowledge arrives, so the destination never sees two toggles merge.
- `req_ready` is low in every state except the IDLE grant cycle. Requesters must not change `req_data` while `req_valid` is high and no grant has been received.
- `cdc_data` changes only on a grant edge. It holds its value through SETTLE, WAIT_ACK and IDLE.
- `timeout_err`:
  - set has priority over `err_clr` when both occur in the same cycle;
  - otherwise `err_clr` clears it on the next edge.
- Reset values:
  - `cdc_data` = 0, `cdc_req_tgl` = 0, `req_ready` = 0, `busy` = 0, `timeout_err` = 0;
  - `grant_idx` = NUM_REQ-1, so requester 0 has first priority;
  - state = IDLE, both counters = 0.
- Reset asserted mid-transfer aborts the transfer immediately with no acknowledge wait. The destination domain is reset together with this block. If it is not, and `cdc_ack_tgl` stays 1, the block remains ungranting in IDLE until the acknowledge returns to 0.

## Timing
- The grant edge is T0. `cdc_data` is valid from T0+1. `cdc_req_tgl` flips at the edge T0+SETTLE_CYCLES.
- With a matching acknowledge arriving k cycles after the flip (k ≥ 1), the state is IDLE from cycle T0+SETTLE_CYCLES+k+1.
- Earliest next grant: the cycle the state is IDLE.
- Minimum grant-to-grant spacing: SETTLE_CYCLES+2 cycles (an acknowledge match on the first WAIT_ACK cycle).
- `busy` and `req_ready` never overlap.
- A `req_valid` deassertion on the grant cycle is a protocol violation and is not handled.

## Test plan
- Single write, default parameters: requester 2 sends 0xDEADBEEF; the acknowledge is echoed 3 cycles after the toggle flips → `req_ready` = 4'b0100 for one cycle, `cdc_data` = 0xDEADBEEF one cycle later, toggle 0→1 two cycles after the grant, `busy` drops one cycle after the acknowledge.
- Round-robin, all four `req_valid` high continuously, instant acknowledge → grant order 0,1,2,3,0, spaced 4 cycles apart.
- Wrap: only requesters 3 and 0 valid, `grant_idx` = 3 → requester 0 is granted next, then 3.
- Timeout, TIMEOUT=5, no acknowledge → `timeout_err` = 1 exactly 5 cycles into WAIT_ACK; state returns to IDLE. A pending `req_valid` gets no grant until `cdc_ack_tgl` is driven to 1, and is granted the next cycle. `err_clr` then clears the flag; `err_clr` coincident with a new timeout leaves it at 1.
- Reset in SETTLE with `cdc_data` = 0xA5A5A5A5 → the next cycle shows `cdc_data` = 0, toggle 0, `busy` 0, `grant_idx` = 3, and no `req_ready` during reset.
- Data stability: randomized traffic with a checker that flags any `cdc_data` change while `busy` is high, or within SETTLE_CYCLES cycles before a toggle flip → zero violations over 10k transfers.

Source files
------------

// File: rtl/cdc_bus_sequencer_if.sv
// Bundle of requester-side and CDC-side signals around the bus sequencer.
// The sequencer takes the master view; the surrounding logic takes the slave view.
interface cdc_bus_sequencer_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         cdc_data;
    logic                     cdc_req_tgl;
    logic                     cdc_ack_tgl;
    logic                     busy;
    logic [IDX_W-1:0]         grant_idx;
    logic                     timeout_err;
    logic                     err_clr;

    modport master (
        input  req_valid, req_data, cdc_ack_tgl, err_clr,
        output req_ready, cdc_data, cdc_req_tgl, busy, grant_idx, timeout_err
    );

    modport slave (
        output req_valid, req_data, cdc_ack_tgl, err_clr,
        input  req_ready, cdc_data, cdc_req_tgl, busy, grant_idx, timeout_err
    );
endinterface

// File: rtl/cdc_bus_sequencer.sv
// Round-robin writer arbiter in front of a shared multi-bit CDC bus: the word is
// held for a settle interval before the request toggle flips, then the ack toggle is awaited.
module cdc_bus_sequencer #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    cdc_bus_sequencer_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETTLE   = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cdc_data_q, cdc_data_d;
    logic               req_tgl_q, req_tgl_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               err_q, err_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

    logic [WIDTH-1:0]   req_word [NUM_REQ];
    logic               parity_ok;
    logic               arb_found;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               grant_fire;
    logic               timeout_set;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end

    // Parity match means the destination has consumed every toggle we sent.
    assign parity_ok  = (bus.cdc_ack_tgl == req_tgl_q);
    assign grant_fire = (state_q == S_IDLE) && parity_ok && arb_found && !rst;

    // Search starts one past the last grant and wraps, giving round-robin order.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_idx_q;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(grant_idx_q) + k) % NUM_REQ);
            if (!arb_found && bus.req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cdc_data_q   <= '0;
            req_tgl_q    <= 1'b0;
            grant_idx_q  <= IDX_W'(NUM_REQ - 1);
            err_q        <= 1'b0;
            settle_cnt_q <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cdc_data_q   <= cdc_data_d;
            req_tgl_q    <= req_tgl_d;
            grant_idx_q  <= grant_idx_d;
            err_q        <= err_d;
            settle_cnt_q <= settle_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cdc_data_d   = cdc_data_q;
        req_tgl_d    = req_tgl_q;
        grant_idx_d  = grant_idx_q;
        settle_cnt_d = settle_cnt_q;
        to_cnt_d     = to_cnt_q;
        timeout_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                settle_cnt_d = '0;
                to_cnt_d     = '0;
                if (grant_fire) begin
                    state_d     = S_SETTLE;
                    cdc_data_d  = req_word[arb_idx];
                    grant_idx_d = arb_idx;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = S_WAIT_ACK;
                    req_tgl_d    = ~req_tgl_q;
                    settle_cnt_d = '0;
                    to_cnt_d     = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (parity_ok) begin
                    state_d = S_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    // The late ack is still owed; IDLE holds off grants until it arrives.
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = timeout_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_fire) begin
            bus.req_ready[arb_idx] = 1'b1;
        end
        bus.busy = (state_q != S_IDLE);
    end

    assign bus.cdc_data    = cdc_data_q;
    assign bus.cdc_req_tgl = req_tgl_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_cdc_bus_sequencer.sv
// Directed and randomized bench for cdc_bus_sequencer with a small ack responder
// (manual, instant echo, or one-cycle delayed echo).
module tb_cdc_bus_sequencer;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst;
    int   ack_mode;
    logic ack_man;
    logic ack_dly = 1'b0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    cdc_bus_sequencer_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    cdc_bus_sequencer #(
        .NUM_REQ(N), .WIDTH(W), .SETTLE_CYCLES(ST), .TIMEOUT(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) ack_dly <= bus.cdc_req_tgl;
    assign bus.cdc_ack_tgl = (ack_mode == 0) ? ack_man :
                             (ack_mode == 1) ? bus.cdc_req_tgl : ack_dly;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] rdy;
        logic [W-1:0] exp_w, prev_data;
        logic         exp_pending, prev_tgl, grant_prev;
        int           stable, grants, cyc, viol, gsel;

        rst = 1'b1; ack_mode = 0; ack_man = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", bus.cdc_data, 0);
        chk("reset_tgl", bus.cdc_req_tgl, 0);
        chk("reset_ready", bus.req_ready, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_gidx", bus.grant_idx, 3);
        chk("reset_err", bus.timeout_err, 0);
        rst = 1'b0;

        // Round-robin with all requesters valid and instant acknowledge
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'h1111_0000 + i;
        ack_mode = 1;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_rdy = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0;
            chk("rr_ready", bus.req_ready, exp_rdy);
            chk("rr_busy", bus.busy, (c % 4 != 0));
            if (c % 4 == 0) $display("rr grant cycle %0d: req_ready %b", c, bus.req_ready);
            if (c % 4 == 1) chk("rr_data", bus.cdc_data, 32'h1111_0000 + (c / 4) % 4);
            if (c == 19) bus.req_valid = '0;
            @(negedge clk);
        end

        // Single write from requester 2, ack 3 cycles after the flip
        ack_man = 1'b1; ack_mode = 0;
        bus.req_data[2*W +: W] = 32'hDEAD_BEEF;
        bus.req_valid = 4'b0100;
        #1 chk("sw_ready", bus.req_ready, 4'b0100);
        $display("single write: req 2 data deadbeef");
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk("sw_ready_drop", bus.req_ready, 0);
        chk("sw_data", bus.cdc_data, 32'hDEAD_BEEF);
        chk("sw_busy", bus.busy, 1);
        chk("sw_gidx", bus.grant_idx, 2);
        chk("sw_tgl_hold", bus.cdc_req_tgl, 1);
        @(negedge clk);
        chk("sw_tgl_hold2", bus.cdc_req_tgl, 1);
        @(negedge clk);
        chk("sw_tgl_flip", bus.cdc_req_tgl, 0);
        repeat (2) @(negedge clk);
        chk("sw_busy_wait", bus.busy, 1);
        ack_man = 1'b0;
        @(negedge clk);
        chk("sw_busy_drop", bus.busy, 0);
        chk("sw_data_hold", bus.cdc_data, 32'hDEAD_BEEF);
        chk("sw_no_err", bus.timeout_err, 0);

        // Wrap-around: grant 3, then with 3 and 0 valid expect 0 then 3
        ack_mode = 1;
        bus.req_valid = 4'b1000;
        #1 chk("wrap_first", bus.req_ready, 4'b1000);
        $display("wrap: grant req 3");
        @(negedge clk);
        bus.req_valid = 4'b1001;
        #1 chk("wrap_gidx3", bus.grant_idx, 3);
        chk("wrap_ready_busy", bus.req_ready, 0);
        repeat (3) @(negedge clk);
        #1 chk("wrap_to0", bus.req_ready, 4'b0001);
        $display("wrap: grant req 0");
        @(negedge clk);
        chk("wrap_gidx0", bus.grant_idx, 0);
        chk("wrap_data0", bus.cdc_data, 32'h1111_0000);
        repeat (3) @(negedge clk);
        #1 chk("wrap_to3", bus.req_ready, 4'b1000);
        $display("wrap: grant req 3");
        @(negedge clk);
        bus.req_valid = '0;
        chk("wrap_data3", bus.cdc_data, 32'h1111_0003);
        repeat (3) @(negedge clk);
        ack_man = 1'b1; ack_mode = 0;

        // Timeout with no acknowledge
        bus.req_data[1*W +: W] = 32'hC0FF_EE01;
        bus.req_valid = 4'b0010;
        #1 chk("to_ready", bus.req_ready, 4'b0010);
        $display("timeout: grant req 1, no ack");
        @(negedge clk);
        bus.req_valid = '0;
        repeat (6) @(negedge clk);
        chk("to_err_pre", bus.timeout_err, 0);
        chk("to_busy_pre", bus.busy, 1);
        @(negedge clk);
        chk("to_err_set", bus.timeout_err, 1);
        chk("to_idle", bus.busy, 0);
        chk("to_tgl", bus.cdc_req_tgl, 0);
        bus.req_valid = 4'b0100;
        #1 chk("to_blocked", bus.req_ready, 0);
        repeat (2) @(negedge clk);
        #1 chk("to_blocked2", bus.req_ready, 0);
        ack_man = 1'b0;
        #1 chk("to_release", bus.req_ready, 4'b0100);
        $display("timeout: late ack, grant req 2");
        @(negedge clk);
        bus.req_valid = '0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_err_clr", bus.timeout_err, 0);
        chk("to_data2", bus.cdc_data, 32'hDEAD_BEEF);
        repeat (5) @(negedge clk);
        chk("to_busy_pre2", bus.busy, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_set_over_clr", bus.timeout_err, 1);
        chk("to_idle2", bus.busy, 0);
        @(negedge clk);
        chk("to_sticky", bus.timeout_err, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("to_clr2", bus.timeout_err, 0);

        // Reset during SETTLE
        ack_man = 1'b1;
        bus.req_data[0*W +: W] = 32'hA5A5_A5A5;
        bus.req_valid = 4'b0001;
        #1 chk("rs_ready", bus.req_ready, 4'b0001);
        $display("reset test: grant req 0 data a5a5a5a5");
        @(negedge clk);
        chk("rs_data", bus.cdc_data, 32'hA5A5_A5A5);
        chk("rs_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_data0", bus.cdc_data, 0);
        chk("rs_tgl0", bus.cdc_req_tgl, 0);
        chk("rs_busy0", bus.busy, 0);
        chk("rs_gidx", bus.grant_idx, 3);
        ack_man = 1'b0;
        #1 chk("rs_ready_gated", bus.req_ready, 0);
        rst = 1'b0;
        #1 chk("rs_ready_after", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        ack_mode = 1;
        repeat (4) @(negedge clk);
        chk("rs_idle", bus.busy, 0);
        ack_mode = 2;
        repeat (2) @(negedge clk);

        // Randomized traffic with data-stability checker
        grants = 0; cyc = 0; viol = 0; stable = ST;
        exp_pending = 1'b0; grant_prev = 1'b0; exp_w = '0;
        prev_data = bus.cdc_data; prev_tgl = bus.cdc_req_tgl;
        while (grants < 10000 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            rdy = bus.req_ready;
            if (exp_pending) begin
                chk("rand_capture", bus.cdc_data, exp_w);
                exp_pending = 1'b0;
            end
            if (bus.cdc_data !== prev_data) begin
                if (!grant_prev) viol++;
                stable = 0;
            end else if (stable < 1000) begin
                stable++;
            end
            if (bus.cdc_req_tgl !== prev_tgl && stable < ST) viol++;
            if (rdy != '0) begin
                if (!$onehot(rdy) || bus.busy) viol++;
                gsel = 0;
                for (int i = 0; i < N; i++) if (rdy[i]) gsel = i;
                if (!bus.req_valid[gsel]) viol++;
                exp_w = bus.req_data[gsel*W +: W];
                exp_pending = 1'b1;
                grants++;
                $display("rand txn %0d: req %0d data %08h", grants, gsel, exp_w);
            end
            grant_prev = (rdy != '0);
            prev_data  = bus.cdc_data;
            prev_tgl   = bus.cdc_req_tgl;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(3) != 0) begin
                        bus.req_valid[i] = 1'b1;
                        bus.req_data[i*W +: W] = $urandom();
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        chk("rand_grants", grants, 10000);
        chk("rand_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
